sensor_frame_scheduler: RTL

Sequences lighthouse sensor capture words out to the ESP over the SPI master's word-stream input.
- Holds off all traffic until the ESP has booted.
- Generates a periodic frame tick.
- Snapshots which of the NUMBER_OF_SENSORS channels hold a fresh word, then emits one header word followed by those words.
- Shares the single SPI link fairly by rotating the start channel each frame.
- Sits between the per-sensor decoders and the SPI master inside the darkroom subsystem.

---
 rtl/sno_pkg.sv | 24 ++
 rtl/rr_first_set.sv | 33 +++
 rtl/sensor_frame_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sno_pkg.sv
// Shared types and constants for sensor_frame_scheduler: FSM states, header layout,
// fill word for channels that withdrew after the snapshot.
package sno_pkg;

  typedef enum logic [2:0] {StBoot, StIdle, StHdr, StScan, StData} sno_state_e;

  localparam logic [7:0]  HDR_MAGIC        = 8'hA5;
  localparam logic [31:0] PLACEHOLDER_WORD = 32'hFFFF_FFFF;

  // Header word layout: [31:24] high byte, [23:16] middle byte, [15:0] frame number
  localparam int unsigned HdrHiLsb    = 24;
  localparam int unsigned HdrMidLsb   = 16;
  localparam int unsigned HdrFrameLsb = 0;

  function automatic logic [7:0] popcount32(input logic [31:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_first_set.sv
// Combinational find-first-set over a mask, searching upward from start_i with wrap-around.
module rr_first_set #(
  parameter  int unsigned N    = 16,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    mask_i,
  input  logic [IdxW-1:0] start_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  localparam logic [IdxW:0] NVal = (IdxW + 1)'(N);

  logic [IdxW:0] cand;

  // Walk offsets from the far end so the nearest hit to start_i is the one left standing.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = {1'b0, start_i} + (IdxW + 1)'(k);
      if (cand >= NVal) begin
        cand = cand - NVal;
      end
      if (mask_i[cand[IdxW-1:0]]) begin
        idx_o   = cand[IdxW-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_frame_scheduler.sv
// Boot-gated, tick-driven frame sequencer: header word then every snapshotted sensor word.
// Optional feature macro SNO_OVERRUN_COUNT_EN adds a dropped-tick counter and alters the header.
module sensor_frame_scheduler
  import sno_pkg::*;
#(
  parameter int unsigned NUMBER_OF_SENSORS = 16,
  parameter int unsigned CLK_SPEED         = 16_000_000,
  parameter int unsigned FRAME_PERIOD_LOG2 = 15,
  parameter int unsigned DATA_W            = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUMBER_OF_SENSORS-1:0]        sensor_valid,
  input  logic [NUMBER_OF_SENSORS*DATA_W-1:0] sensor_data,
  output logic [NUMBER_OF_SENSORS-1:0]        sensor_ack,
  output logic                                esp_en,
  output logic                                esp_ready,
  output logic [DATA_W-1:0]                   tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                tx_last,
  output logic [15:0]                         frame_count
`ifdef SNO_OVERRUN_COUNT_EN
  ,
  output logic [7:0]                          overrun_count
`endif
);

  localparam int unsigned N     = NUMBER_OF_SENSORS;
  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned BootW = $clog2(CLK_SPEED + 1);
  localparam logic [BootW-1:0] BootLimit = BootW'(CLK_SPEED);
  localparam logic [IdxW-1:0]  LastIdx   = IdxW'(N - 1);

  sno_state_e                   state_q, state_d;
  logic [BootW-1:0]             boot_cnt_q, boot_cnt_d;
  logic                         esp_en_q, esp_en_d, esp_ready_q, esp_ready_d;
  logic [FRAME_PERIOD_LOG2-1:0] tick_cnt_q, tick_cnt_d;
  logic                         pending_q, pending_d;
  logic [N-1:0]                 mask_q, mask_d, scan_mask;
  logic [IdxW-1:0]              start_q, start_d, rr_idx;
  logic [15:0]                  frame_q, frame_d;
  logic                         tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [DATA_W-1:0]            tx_data_q, tx_data_d;
  logic [N-1:0]                 ack_q, ack_d;
  logic                         rr_found, tick, consume, frame_done;
  logic [7:0]                   pop;
  logic [31:0]                  hdr_word;
`ifdef SNO_OVERRUN_COUNT_EN
  logic [7:0]                   overrun_q, overrun_d;
`endif

  rr_first_set #(
    .N(N)
  ) u_rr_first_set (
    .mask_i  (mask_q),
    .start_i (start_q),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  always_comb begin
    esp_en_d    = 1'b1;
    esp_ready_d = esp_ready_q | (boot_cnt_q == BootLimit);
    boot_cnt_d  = (boot_cnt_q == BootLimit) ? boot_cnt_q : boot_cnt_q + 1'b1;
    tick_cnt_d  = tick_cnt_q + 1'b1;
    tick        = esp_ready_q && (tick_cnt_q == '1);
    state_d     = state_q;
    mask_d      = mask_q;
    scan_mask   = mask_q;
    start_d     = start_q;
    frame_d     = frame_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tx_last_d   = tx_last_q;
    ack_d       = '0;
    consume     = 1'b0;
    frame_done  = 1'b0;

    pop      = popcount32(32'(sensor_valid));
    hdr_word = '0;
    hdr_word[HdrFrameLsb +: 16] = frame_q;
`ifdef SNO_OVERRUN_COUNT_EN
    hdr_word[HdrHiLsb +: 8]  = pop;
    hdr_word[HdrMidLsb +: 8] = overrun_q;
`else
    hdr_word[HdrHiLsb +: 8]  = HDR_MAGIC;
    hdr_word[HdrMidLsb +: 8] = pop;
`endif

    unique case (state_q)
      StBoot: if (esp_ready_q) state_d = StIdle;
      StIdle: begin
        if (pending_q) begin
          consume    = 1'b1;
          mask_d     = sensor_valid;
          tx_valid_d = 1'b1;
          tx_data_d  = DATA_W'(hdr_word);
          tx_last_d  = (sensor_valid == '0);
          state_d    = StHdr;
        end
      end
      StHdr: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          frame_done = (mask_q == '0);
          state_d    = (mask_q == '0) ? StIdle : StScan;
        end
      end
      StScan: begin
        // A channel that withdrew after the snapshot still gets a slot, sent as all-ones.
        scan_mask[rr_idx] = 1'b0;
        mask_d            = scan_mask;
        ack_d[rr_idx]     = sensor_valid[rr_idx] & rr_found;
        tx_data_d         = sensor_valid[rr_idx] ? sensor_data[32'(rr_idx) * DATA_W +: DATA_W]
                                                 : DATA_W'(PLACEHOLDER_WORD);
        tx_last_d         = (scan_mask == '0);
        tx_valid_d        = 1'b1;
        state_d           = StData;
      end
      StData: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          frame_done = tx_last_q;
          state_d    = tx_last_q ? StIdle : StScan;
        end
      end
      default: state_d = StBoot;
    endcase

    if (frame_done) begin
      frame_d = frame_q + 16'd1;
      start_d = (start_q == LastIdx) ? '0 : start_q + 1'b1;
    end

    // A tick in the consuming cycle re-arms pending rather than being lost.
    pending_d = tick ? 1'b1 : (consume ? 1'b0 : pending_q);
`ifdef SNO_OVERRUN_COUNT_EN
    overrun_d = (tick && pending_q && !consume && overrun_q != 8'hFF) ? overrun_q + 8'd1
                                                                     : overrun_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      boot_cnt_q  <= '0;
      esp_en_q    <= 1'b0;
      esp_ready_q <= 1'b0;
      tick_cnt_q  <= '0;
      pending_q   <= 1'b0;
      mask_q      <= '0;
      start_q     <= '0;
      frame_q     <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_last_q   <= 1'b0;
      ack_q       <= '0;
`ifdef SNO_OVERRUN_COUNT_EN
      overrun_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      esp_en_q    <= esp_en_d;
      esp_ready_q <= esp_ready_d;
      tick_cnt_q  <= tick_cnt_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      start_q     <= start_d;
      frame_q     <= frame_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_last_q   <= tx_last_d;
      ack_q       <= ack_d;
`ifdef SNO_OVERRUN_COUNT_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign sensor_ack  = ack_q;
  assign esp_en      = esp_en_q;
  assign esp_ready   = esp_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_last_q;
  assign frame_count = frame_q;
`ifdef SNO_OVERRUN_COUNT_EN
  assign overrun_count = overrun_q;
`endif

endmodule
